// File: rtl/up_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Package : up_pkg                                                        |
// | Purpose : Shared widths, opcode constants and FSM state type for the    |
// |           up_op_seq operation sequencer and its ALU.                    |
// | Ports   : n/a                                                           |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
package up_pkg;

  localparam int DATA_W = 8;  // matches the 8-bit register block
  localparam int SEL_W  = 2;  // 4 registers

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/up_op_seq_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Interface : up_op_seq_if                                                |
// | Purpose   : Bundles the instruction handshake, register-block access    |
// |             and status signals of the operation sequencer.              |
// | Modports  : master - environment side (drives instr_*, rf_data_out_*)   |
// |             slave  - sequencer side (drives ready, selects, write data, |
// |                      write enable, flags, done)                         |
// | Rev       : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
interface up_op_seq_if;
  import up_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [SEL_W-1:0]  instr_rd;
  logic [SEL_W-1:0]  instr_ra;
  logic [SEL_W-1:0]  instr_rb;
  logic [DATA_W-1:0] instr_imm;
  logic [SEL_W-1:0]  rf_sel_out_a;
  logic [SEL_W-1:0]  rf_sel_out_b;
  logic [DATA_W-1:0] rf_data_out_a;
  logic [DATA_W-1:0] rf_data_out_b;
  logic [SEL_W-1:0]  rf_sel_in;
  logic [DATA_W-1:0] rf_data_in;
  logic              rf_we;
  logic              flag_z;
  logic              flag_c;
  logic              done;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
    output rf_data_out_a, rf_data_out_b,
    input  instr_ready, rf_sel_out_a, rf_sel_out_b, rf_sel_in, rf_data_in,
    input  rf_we, flag_z, flag_c, done
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
    input  rf_data_out_a, rf_data_out_b,
    output instr_ready, rf_sel_out_a, rf_sel_out_b, rf_sel_in, rf_data_in,
    output rf_we, flag_z, flag_c, done
  );

endinterface
`default_nettype wire

// File: rtl/up_alu.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : up_alu                                                        |
// | Purpose : Combinational 8-bit ALU for the operation sequencer.          |
// | Ports   : op     in  opcode                                             |
// |           a, b   in  operands captured from the register block          |
// |           imm    in  immediate (LDI only)                               |
// |           result out 8-bit result, mod 2^8                              |
// |           carry  out ADD carry-out / SUB borrow, 0 for all other ops    |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
module up_alu
  import up_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);  // borrow
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/up_op_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : up_op_seq                                                     |
// | Purpose : Four-state instruction sequencer (IDLE/READ/EXEC/WB) driving  |
// |           a 4 x 8-bit two-read/one-write register block.                |
// | Ports   : clk   in  clock, rising edge                                  |
// |           nRst  in  asynchronous active-low reset                       |
// |           bus   up_op_seq_if.slave: instruction handshake, register     |
// |                 read/write selects and data, rf_we, flags, done         |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
module up_op_seq
  import up_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  up_op_seq_if.slave  bus
);

  state_t            state_q;
  logic [2:0]        op_q;
  logic [SEL_W-1:0]  rd_q;
  logic [SEL_W-1:0]  ra_q;
  logic [SEL_W-1:0]  rb_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic              ready_q;
  logic              we_q;
  logic              done_q;
  logic              z_q;
  logic              c_q;

  logic [DATA_W-1:0] alu_result_d;
  logic              alu_carry_d;

  up_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_result_d),
    .carry  (alu_carry_d)
  );

  // All outputs are registered; rf_we/done are set on the EXEC->WB edge so
  // they are high exactly during WB.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.instr_valid) begin
            op_q    <= bus.instr_op;
            rd_q    <= bus.instr_rd;
            ra_q    <= bus.instr_ra;
            rb_q    <= bus.instr_rb;
            imm_q   <= bus.instr_imm;
            ready_q <= 1'b0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          a_q     <= bus.rf_data_out_a;
          b_q     <= bus.rf_data_out_b;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // NOP leaves the result register alone so rf_data_in keeps
          // showing the last written value.
          if (op_q != OP_NOP) begin
            result_q <= alu_result_d;
            carry_q  <= alu_carry_d;
          end
          we_q    <= (op_q != OP_NOP);
          done_q  <= 1'b1;
          state_q <= S_WB;
        end
        S_WB: begin
          if (op_q != OP_NOP) begin
            z_q <= (result_q == '0);
            c_q <= carry_q;
          end
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready  = ready_q;
  assign bus.rf_sel_out_a = ra_q;
  assign bus.rf_sel_out_b = rb_q;
  assign bus.rf_sel_in    = rd_q;
  assign bus.rf_data_in   = result_q;
  assign bus.rf_we        = we_q;
  assign bus.done         = done_q;
  assign bus.flag_z       = z_q;
  assign bus.flag_c       = c_q;

endmodule
`default_nettype wire

// File: tb/tb_up_op_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : tb_up_op_seq                                                  |
// | Purpose : Self-checking bench for up_op_seq with a behavioural register |
// |           block and an arithmetic reference model.                      |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
module tb_up_op_seq;
  import up_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] imm;
  } instr_t;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic rf_init = 1'b0;
  logic [7:0] rf [4];

  int pass_cnt = 0;
  int total = 0;

  // reference model state
  int   mdl_rf [4];
  logic mdl_z, mdl_c;

  // observations captured by send()
  logic       obs_busy, obs_early, obs_we, obs_done, obs_rdy, obs_z, obs_c, obs_after;
  logic [1:0] obs_sela, obs_selb, obs_sel;
  logic [7:0] obs_data;

  up_op_seq_if bus();

  up_op_seq dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // behavioural register block: combinational reads, write on rising edge
  assign bus.rf_data_out_a = rf[bus.rf_sel_out_a];
  assign bus.rf_data_out_b = rf[bus.rf_sel_out_b];
  always @(posedge clk) begin
    if (rf_init) begin
      rf[0] <= 8'h01; rf[1] <= 8'h02; rf[2] <= 8'h03; rf[3] <= 8'h04;
    end else if (bus.rf_we) begin
      rf[bus.rf_sel_in] <= bus.rf_data_in;
    end
  end

  function automatic instr_t mk(input logic [2:0] op, input logic [1:0] rd, ra, rb,
                                input logic [7:0] imm);
    instr_t i;
    i.op = op; i.rd = rd; i.ra = ra; i.rb = rb; i.imm = imm;
    return i;
  endfunction

  // {carry, result} from the opcode rules using plain integer arithmetic
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input int a, b, imm);
    int r;
    logic c;
    c = 1'b0;
    r = 0;
    case (op)
      3'd0: begin r = a + b; c = (r > 255); r = r % 256; end
      3'd1: begin c = (a < b); r = (a - b + 256) % 256; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a;
      3'd6: r = imm;
      default: r = 0;
    endcase
    return {c, r[7:0]};
  endfunction

  task automatic predict(input instr_t ins, output logic [7:0] d, output logic w);
    logic [8:0] r;
    r = ref_alu(ins.op, mdl_rf[ins.ra], mdl_rf[ins.rb], int'(ins.imm));
    d = r[7:0];
    w = (ins.op != OP_NOP);
    if (w) begin
      mdl_rf[ins.rd] = int'(r[7:0]);
      mdl_z = (r[7:0] == 8'h00);
      mdl_c = r[8];
    end
  endtask

  task automatic do_reset();
    nRst = 1'b0; rf_init = 1'b1;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
    bus.instr_ra = '0; bus.instr_rb = '0; bus.instr_imm = '0;
    @(negedge clk);
    @(negedge clk);
    rf_init = 1'b0; nRst = 1'b1;
    @(negedge clk);
    mdl_rf[0] = 1; mdl_rf[1] = 2; mdl_rf[2] = 3; mdl_rf[3] = 4;
    mdl_z = 1'b0; mdl_c = 1'b0;
  endtask

  // Drives one instruction from IDLE and records what the DUT shows in each
  // of the following four cycles; returns at the negedge of the IDLE cycle.
  task automatic send(input instr_t ins);
    bus.instr_valid = 1'b1; bus.instr_op = ins.op; bus.instr_rd = ins.rd;
    bus.instr_ra = ins.ra; bus.instr_rb = ins.rb; bus.instr_imm = ins.imm;
    @(negedge clk);  // READ
    bus.instr_valid = 1'b0;
    obs_sela = bus.rf_sel_out_a; obs_selb = bus.rf_sel_out_b;
    obs_busy = bus.instr_ready;
    @(negedge clk);  // EXEC
    obs_busy = obs_busy | bus.instr_ready;
    obs_early = bus.rf_we | bus.done;
    @(negedge clk);  // WB
    obs_busy = obs_busy | bus.instr_ready;
    obs_we = bus.rf_we; obs_done = bus.done; obs_sel = bus.rf_sel_in; obs_data = bus.rf_data_in;
    @(negedge clk);  // back in IDLE
    obs_rdy = bus.instr_ready; obs_z = bus.flag_z; obs_c = bus.flag_c;
    obs_after = bus.rf_we | bus.done;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.instr_ready); else pass_cnt++;
    total++; if (bus.rf_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.rf_we); else pass_cnt++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
    total++; if ({bus.flag_z, bus.flag_c} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {bus.flag_z, bus.flag_c}); else pass_cnt++;
    total++; if ({bus.rf_sel_out_a, bus.rf_sel_out_b, bus.rf_sel_in} !== 6'd0) $display("FAIL reset_sels: got %h want 0", {bus.rf_sel_out_a, bus.rf_sel_out_b, bus.rf_sel_in}); else pass_cnt++;
    total++; if (bus.rf_data_in !== 8'h00) $display("FAIL reset_data_in: got %h want 00", bus.rf_data_in); else pass_cnt++;
  endtask

  task automatic test_add();
    logic [7:0] d; logic w;
    do_reset();
    predict(mk(OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00), d, w);
    send(mk(OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00));
    total++; if ({obs_sela, obs_selb} !== {2'd1, 2'd2}) $display("FAIL add_read_sel: got %h want 6", {obs_sela, obs_selb}); else pass_cnt++;
    total++; if (obs_busy !== 1'b0) $display("FAIL add_ready_busy: got %b want 0", obs_busy); else pass_cnt++;
    total++; if (obs_early !== 1'b0) $display("FAIL add_early_we: got %b want 0", obs_early); else pass_cnt++;
    total++; if ({obs_we, obs_done} !== 2'b11) $display("FAIL add_wb_we_done: got %b want 11", {obs_we, obs_done}); else pass_cnt++;
    total++; if (obs_sel !== 2'd0) $display("FAIL add_wb_sel: got %0d want 0", obs_sel); else pass_cnt++;
    total++; if (obs_data !== 8'h05 || obs_data !== d) $display("FAIL add_wb_data: got %h want 05", obs_data); else pass_cnt++;
    total++; if ({obs_z, obs_c} !== 2'b00) $display("FAIL add_flags: got %b want 00", {obs_z, obs_c}); else pass_cnt++;
    total++; if ({obs_rdy, obs_after} !== 2'b10) $display("FAIL add_idle: got %b want 10", {obs_rdy, obs_after}); else pass_cnt++;
  endtask

  task automatic test_ldi_add();
    logic [7:0] d; logic w;
    predict(mk(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hFF), d, w);
    send(mk(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hFF));
    total++; if (obs_data !== 8'hFF) $display("FAIL ldi_data: got %h want ff", obs_data); else pass_cnt++;
    predict(mk(OP_ADD, 2'd2, 2'd1, 2'd3, 8'h00), d, w);
    send(mk(OP_ADD, 2'd2, 2'd1, 2'd3, 8'h00));
    total++; if (obs_sel !== 2'd2 || obs_data !== d) $display("FAIL ldi_add_wb: got sel %0d data %h want sel 2 data %h", obs_sel, obs_data, d); else pass_cnt++;
    total++; if ({obs_z, obs_c} !== 2'b01) $display("FAIL ldi_add_flags: got zc=%b want 01", {obs_z, obs_c}); else pass_cnt++;
  endtask

  task automatic test_sub();
    logic [7:0] d; logic w;
    do_reset();
    predict(mk(OP_SUB, 2'd0, 2'd0, 2'd0, 8'h00), d, w);
    send(mk(OP_SUB, 2'd0, 2'd0, 2'd0, 8'h00));
    total++; if (obs_data !== 8'h00) $display("FAIL sub_zero_data: got %h want 00", obs_data); else pass_cnt++;
    total++; if ({obs_z, obs_c} !== 2'b10) $display("FAIL sub_zero_flags: got zc=%b want 10", {obs_z, obs_c}); else pass_cnt++;
    predict(mk(OP_SUB, 2'd1, 2'd0, 2'd1, 8'h00), d, w);
    send(mk(OP_SUB, 2'd1, 2'd0, 2'd1, 8'h00));
    total++; if (obs_data !== 8'hFE || obs_data !== d) $display("FAIL sub_borrow_data: got %h want fe", obs_data); else pass_cnt++;
    total++; if ({obs_z, obs_c} !== 2'b01) $display("FAIL sub_borrow_flags: got zc=%b want 01", {obs_z, obs_c}); else pass_cnt++;
  endtask

  task automatic test_nop();
    logic [7:0] d; logic w;
    do_reset();
    predict(mk(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h80), d, w);
    send(mk(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h80));
    predict(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00), d, w);
    send(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00));
    total++; if ({obs_data, obs_z, obs_c} !== {8'h00, 2'b11}) $display("FAIL nop_pre_add: got %h zc=%b want 00 zc=11", obs_data, {obs_z, obs_c}); else pass_cnt++;
    predict(mk(OP_NOP, 2'd2, 2'd1, 2'd1, 8'h55), d, w);
    send(mk(OP_NOP, 2'd2, 2'd1, 2'd1, 8'h55));
    total++; if ({obs_we, obs_done} !== 2'b01) $display("FAIL nop_we_done: got %b want 01", {obs_we, obs_done}); else pass_cnt++;
    total++; if ({obs_z, obs_c} !== {mdl_z, mdl_c}) $display("FAIL nop_flags: got zc=%b want %b", {obs_z, obs_c}, {mdl_z, mdl_c}); else pass_cnt++;
    total++; if (int'(rf[2]) != mdl_rf[2]) $display("FAIL nop_r2: got %h want %h", rf[2], mdl_rf[2]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    instr_t q[$];
    logic [7:0] exp_d[$];
    int accepts[$];
    int rdy_err, data_err, dones, acc_bad;
    logic hs, w;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 4; i++)
      q.push_back(mk(OP_XOR, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 8'h00));
    rdy_err = 0; data_err = 0; dones = 0;
    for (int k = 0; k < 16; k++) begin
      if (q.size() > 0) begin
        bus.instr_valid = 1'b1; bus.instr_op = q[0].op; bus.instr_rd = q[0].rd;
        bus.instr_ra = q[0].ra; bus.instr_rb = q[0].rb; bus.instr_imm = q[0].imm;
      end else begin
        bus.instr_valid = 1'b0;
      end
      if (bus.instr_ready !== ((k % 4) == 0)) rdy_err++;
      hs = bus.instr_valid && bus.instr_ready;
      @(negedge clk);
      if (hs) begin
        accepts.push_back(k);
        predict(q[0], d, w);
        exp_d.push_back(d);
        void'(q.pop_front());
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (exp_d.size() == 0 || bus.rf_data_in !== exp_d[0]) data_err++;
        if (exp_d.size() > 0) void'(exp_d.pop_front());
      end
    end
    bus.instr_valid = 1'b0;
    acc_bad = (accepts.size() == 4) ? 0 : 1;
    foreach (accepts[i]) if (accepts[i] != 4 * i) acc_bad = 1;
    total++; if (accepts.size() != 4) $display("FAIL b2b_accept_count: got %0d want 4", accepts.size()); else pass_cnt++;
    total++; if (acc_bad != 0) $display("FAIL b2b_accept_cycles: got mismatch flag %0d want 0", acc_bad); else pass_cnt++;
    total++; if (rdy_err != 0) $display("FAIL b2b_ready: got %0d bad cycles want 0", rdy_err); else pass_cnt++;
    total++; if (dones != 4) $display("FAIL b2b_done_count: got %0d want 4", dones); else pass_cnt++;
    total++; if (data_err != 0) $display("FAIL b2b_data: got %0d bad results want 0", data_err); else pass_cnt++;
    for (int r = 0; r < 4; r++) begin
      total++; if (int'(rf[r]) != mdl_rf[r]) $display("FAIL b2b_rf%0d: got %h want %h", r, rf[r], mdl_rf[r]); else pass_cnt++;
    end
    total++; if ({bus.flag_z, bus.flag_c} !== {mdl_z, mdl_c}) $display("FAIL b2b_flags: got %b want %b", {bus.flag_z, bus.flag_c}, {mdl_z, mdl_c}); else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    int we_seen;
    do_reset();
    we_seen = 0;
    bus.instr_valid = 1'b1; bus.instr_op = OP_ADD; bus.instr_rd = 2'd3;
    bus.instr_ra = 2'd1; bus.instr_rb = 2'd2; bus.instr_imm = 8'h00;
    @(negedge clk);  // READ
    bus.instr_valid = 1'b0;
    @(negedge clk);  // EXEC
    nRst = 1'b0;
    #1;
    total++; if (bus.instr_ready !== 1'b1) $display("FAIL rstx_async_ready: got %b want 1", bus.instr_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rf_we !== 1'b0 || bus.done !== 1'b0) we_seen++;
    end
    nRst = 1'b1;
    @(negedge clk);
    if (bus.rf_we !== 1'b0 || bus.done !== 1'b0) we_seen++;
    total++; if (we_seen != 0) $display("FAIL rstx_no_write: got %0d active cycles want 0", we_seen); else pass_cnt++;
    total++; if (bus.instr_ready !== 1'b1) $display("FAIL rstx_ready: got %b want 1", bus.instr_ready); else pass_cnt++;
    total++; if ({bus.rf_sel_out_a, bus.rf_sel_out_b, bus.rf_sel_in, bus.rf_data_in} !== 14'd0) $display("FAIL rstx_outputs: got %h want 0", {bus.rf_sel_out_a, bus.rf_sel_out_b, bus.rf_sel_in, bus.rf_data_in}); else pass_cnt++;
    total++; if ({bus.flag_z, bus.flag_c} !== 2'b00) $display("FAIL rstx_flags: got %b want 00", {bus.flag_z, bus.flag_c}); else pass_cnt++;
    total++; if (rf[3] !== 8'h04) $display("FAIL rstx_r3: got %h want 04", rf[3]); else pass_cnt++;
  endtask

  task automatic test_random();
    instr_t ins;
    logic [7:0] d;
    logic w;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      ins = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      predict(ins, d, w);
      send(ins);
      total++; if ({obs_we, obs_done, obs_busy} !== {w, 2'b10}) $display("FAIL rnd%0d_ctrl: op %0d got we/done/busy %b want %b", n, ins.op, {obs_we, obs_done, obs_busy}, {w, 2'b10}); else pass_cnt++;
      if (w) begin
        total++; if ({obs_sel, obs_data} !== {ins.rd, d}) $display("FAIL rnd%0d_wb: op %0d got sel %0d data %h want sel %0d data %h", n, ins.op, obs_sel, obs_data, ins.rd, d); else pass_cnt++;
      end
      total++; if ({obs_z, obs_c} !== {mdl_z, mdl_c}) $display("FAIL rnd%0d_flags: op %0d got zc=%b want %b", n, ins.op, {obs_z, obs_c}, {mdl_z, mdl_c}); else pass_cnt++;
    end
    for (int r = 0; r < 4; r++) begin
      total++; if (int'(rf[r]) != mdl_rf[r]) $display("FAIL rnd_rf%0d: got %h want %h", r, rf[r], mdl_rf[r]); else pass_cnt++;
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
    bus.instr_ra = '0; bus.instr_rb = '0; bus.instr_imm = '0;
    test_reset();
    test_add();
    test_ldi_add();
    test_sub();
    test_nop();
    test_back_to_back();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
